// File: rtl/mac_pipe_element_if.sv
// Operand/result stream bundle for mac_pipe_element: input beat (a, b, mode, clr)
// with valid/ready, and output beat (acc, sat) with valid/ready.
interface mac_pipe_element_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_a;
    logic [DATA_W-1:0] i_b;
    logic [1:0]        i_mode;
    logic              i_acc_clr;
    logic              o_valid;
    logic              i_ready;
    logic [ACC_W-1:0]  o_acc;
    logic              o_sat;

    modport slave (
        input  i_valid, i_a, i_b, i_mode, i_acc_clr, i_ready,
        output o_ready, o_valid, o_acc, o_sat
    );

    modport master (
        output i_valid, i_a, i_b, i_mode, i_acc_clr, i_ready,
        input  o_ready, o_valid, o_acc, o_sat
    );
endinterface

// File: rtl/mac_pipe_element.sv
// Flow-controlled sum/product -> delay -> combine -> accumulate element.
// Define MAC_PIPE_SAT_EN for an unsigned saturating accumulator with sticky o_sat.
module mac_pipe_element #(
    parameter int DATA_W       = 32,
    parameter int ACC_W        = 32,
    parameter int EXTRA_STAGES = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    mac_pipe_element_if.slave    bus
);
    // S1 and the pure-delay stages share one register array; index NS-1 feeds S2
    localparam int NS = EXTRA_STAGES + 1;

    logic [DATA_W-1:0] w_sum_p0;
    logic [DATA_W-1:0] w_prod_p0;

    logic [DATA_W-1:0] r_sum_p1  [NS];
    logic [DATA_W-1:0] r_prod_p1 [NS];
    logic [1:0]        r_mode_p1 [NS];
    logic              r_clr_p1  [NS];
    logic [NS-1:0]     r_vld_p1;
    logic [NS-1:0]     w_en_p1;

    logic [DATA_W-1:0] r_term_p2;
    logic              r_clr_p2;
    logic              r_vld_p2;
    logic              w_en_p2;

    logic [ACC_W-1:0]  r_acc_p3;
    logic              r_vld_p3;
    logic              w_en_p3;
    logic [ACC_W-1:0]  w_base_p3;
    logic [ACC_W-1:0]  w_acc_nxt_p3;

    function automatic logic [DATA_W-1:0] f_combine(
        input logic [1:0]        mode,
        input logic [DATA_W-1:0] sum,
        input logic [DATA_W-1:0] prod
    );
        case (mode)
            2'd0:    f_combine = sum ^ prod;
            2'd1:    f_combine = sum;
            2'd2:    f_combine = prod;
            default: f_combine = sum + prod;
        endcase
    endfunction

`ifdef MAC_PIPE_SAT_EN
    logic              r_sat_p3;
    logic              w_sat_nxt_p3;
    logic [ACC_W:0]    w_raw_p3;

    function automatic logic [ACC_W-1:0] f_sat(input logic [ACC_W:0] raw);
        f_sat = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
    endfunction
`endif

    assign w_sum_p0  = bus.i_a + bus.i_b;
    assign w_prod_p0 = bus.i_a * bus.i_b;

    // A stage may load when it is empty or its content moves on this cycle
    always_comb begin
        logic en;
        w_en_p3 = ~r_vld_p3 | bus.i_ready;
        w_en_p2 = ~r_vld_p2 | w_en_p3;
        en      = w_en_p2;
        w_en_p1 = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            en         = ~r_vld_p1[k] | en;
            w_en_p1[k] = en;
        end
    end

    always_comb begin
        w_base_p3 = r_clr_p2 ? '0 : r_acc_p3;
`ifdef MAC_PIPE_SAT_EN
        w_raw_p3     = {1'b0, w_base_p3} + (ACC_W + 1)'(r_term_p2);
        w_acc_nxt_p3 = f_sat(w_raw_p3);
        w_sat_nxt_p3 = w_raw_p3[ACC_W] | (~r_clr_p2 & r_sat_p3);
`else
        w_acc_nxt_p3 = w_base_p3 + ACC_W'(r_term_p2);
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld_p1 <= '0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
            r_acc_p3 <= '0;
        end else begin
            if (w_en_p1[0]) r_vld_p1[0] <= bus.i_valid;
            for (int k = 1; k < NS; k++) begin
                if (w_en_p1[k]) r_vld_p1[k] <= r_vld_p1[k-1];
            end
            if (w_en_p2) r_vld_p2 <= r_vld_p1[NS-1];
            if (w_en_p3) r_vld_p3 <= r_vld_p2;
            if (w_en_p3 && r_vld_p2) r_acc_p3 <= w_acc_nxt_p3;
        end
    end

`ifdef MAC_PIPE_SAT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sat_p3 <= 1'b0;
        end else if (w_en_p3 && r_vld_p2) begin
            r_sat_p3 <= w_sat_nxt_p3;
        end
    end

    assign bus.o_sat = r_sat_p3;
`else
    assign bus.o_sat = 1'b0;
`endif

    // ---- S1 / delay stages -> S2 data path (no reset on data) ----
    always_ff @(posedge i_clk) begin
        if (w_en_p1[0]) begin
            r_sum_p1[0]  <= w_sum_p0;
            r_prod_p1[0] <= w_prod_p0;
            r_mode_p1[0] <= bus.i_mode;
            r_clr_p1[0]  <= bus.i_acc_clr;
        end
        for (int k = 1; k < NS; k++) begin
            if (w_en_p1[k]) begin
                r_sum_p1[k]  <= r_sum_p1[k-1];
                r_prod_p1[k] <= r_prod_p1[k-1];
                r_mode_p1[k] <= r_mode_p1[k-1];
                r_clr_p1[k]  <= r_clr_p1[k-1];
            end
        end
        if (w_en_p2) begin
            r_term_p2 <= f_combine(r_mode_p1[NS-1], r_sum_p1[NS-1], r_prod_p1[NS-1]);
            r_clr_p2  <= r_clr_p1[NS-1];
        end
    end

    assign bus.o_ready = w_en_p1[0];
    assign bus.o_valid = r_vld_p3;
    assign bus.o_acc   = r_acc_p3;
endmodule
